ifetch_queue: RTL

- Instruction-fetch front end that sits between the program counter/branch logic and the decode stage.
- Owns a fetch pointer and issues reads to the synchronous instruction ROM, which has 1-cycle read latency.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and hands them to decode with a valid/ready handshake.
- A redirect (program start or taken branch) flushes the FIFO and restarts fetch at a new PC.

---
 rtl/ifetch_queue.sv | 71 +++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch pointer, 1-cycle ROM read issue and PC-tagged instruction FIFO toward decode.
module ifetch_queue #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 9,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       imem_rd_en,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [PC_W-1:0]    fetch_ptr, inflight_pc;
    logic               inflight, push, pop;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [AW-1:0]      head, tail;
    logic [CW-1:0]      count;
    // A read is only issued when a slot is reserved for its return, so the FIFO cannot overflow
    assign imem_rd_en = reset && !redirect && (count + CW'(inflight) < CW'(DEPTH));
    assign imem_addr  = fetch_ptr;
    assign push       = inflight && !redirect;
    assign pop        = out_valid && out_ready;
    assign out_valid  = count != '0;
    assign out_instr  = mem_instr[head];
    assign out_pc     = mem_pc[head];
    assign occupancy  = count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_ptr   <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (redirect) begin
            fetch_ptr <= redirect_pc;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                fetch_ptr   <= fetch_ptr + PC_W'(1);
                inflight_pc <= fetch_ptr;
            end
            if (push) begin
                mem_instr[tail] <= imem_data;
                mem_pc[tail]    <= inflight_pc;
                tail            <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
